regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single regfile write port between NREQ writeback sources (ALU, load unit, MUL/DIV)
//   using round-robin arbitration with a valid/ready handshake. Also keeps a per-register pending
//   (busy) scoreboard, set at issue and cleared at writeback, which the issue stage uses for RAW/WAW
//   stalls. Sits between the execute-side writeback sources and the regfile write port.
// PARAMETERS
//   NREQ    3   number of writeback requesters (>=2)
//   REG_W   5   register index width; 2**REG_W registers, x0 hard-wired zero
//   WORD_W  32  data width
// PORTS
//   clk        in   1             clock, rising edge
//   nrst       in   1             asynchronous active-low reset
//   req_valid  in   NREQ          requester i holds a writeback
//   req_ready  out  NREQ          grant to requester i; transfer when valid&ready
//   req_rd     in   NREQ*REG_W    dest index, requester i at [i*REG_W +: REG_W]
//   req_data   in   NREQ*WORD_W   write data, requester i at [i*WORD_W +: WORD_W]
//   iss_valid  in   1             instruction issued with a destination register
//   iss_rd     in   REG_W         destination of the issued instruction
//   rf_wen     out  1             regfile write enable
//   rf_wsel    out  REG_W         regfile write index
//   rf_wdat    out  WORD_W        regfile write data
//   busy       out  2**REG_W      scoreboard: bit r = write to xr pending
// BEHAVIOUR
//   Reset (nrst low, async): rf_wen=0, rf_wsel=0, rf_wdat=0, busy=0, rr pointer=0; req_ready forced 0.
//     Reset mid-operation discards the output stage and all busy bits; no write reaches regfile.
//   Arbitration (combinational, per cycle): search req_valid starting at pointer p, ascending mod
//     NREQ; first valid index g gets req_ready[g]=1, all others 0. None valid -> req_ready=0.
//   At most one grant per cycle; output stage never stalls, so a granted request always transfers.
//   Pointer: on transfer by g, p <= (g+1) mod NREQ; no transfer -> p unchanged.
//   Requesters hold valid/rd/data stable until ready; valid may not drop without a transfer.
//   Output stage (registered, latency 1): transfer in cycle N -> cycle N+1 rf_wsel=rd, rf_wdat=data,
//     rf_wen=(rd!=0), for exactly one cycle. No transfer in N -> rf_wen=0 in N+1 (wsel/wdat hold).
//   rd=0 request: granted and consumes the slot and pointer advance, but rf_wen stays 0.
//   Scoreboard, evaluated at each rising edge:
//     set:   iss_valid & iss_rd!=0 -> busy[iss_rd] <= 1
//     clear: rf_wen=1 this cycle -> busy[rf_wsel] <= 0 (same edge the regfile commits)
//     same register set and cleared on one edge -> set wins (busy stays 1, new producer).
//     issue to an already-busy register keeps bit at 1 (single bit, not a count); the first
//       writeback clears it. Issue stage is required to stall WAW on busy.
//     busy[0] constant 0.
//   busy reflects registered state only; no same-cycle bypass of set or clear.
// TESTING
//   1 Single req: req_valid=001, rd=5, data=0xDEADBEEF in cycle N -> req_ready=001 in N;
//     N+1 rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF; N+2 rf_wen=0.
//   2 All valid held 6 cycles after reset -> grant order 0,1,2,0,1,2; rf_wsel follows each rd.
//   3 Fairness: req1 valid continuously, req0 valid every other cycle -> req0 never waits >1 grant.
//   4 Scoreboard: iss rd=7 -> busy[7]=1 next cycle; wb rd=7 -> busy[7]=0 after rf_wen cycle;
//     repeat with iss rd=7 on the edge of that rf_wen -> busy[7] stays 1.
//   5 x0: iss rd=0 -> busy=0; req rd=0 data=0x1 -> req_ready pulses, rf_wen stays 0, pointer advances.
//   6 Reset mid-op: busy[3],busy[9] set, transfer in flight, nrst low between edges -> outputs and
//     busy 0 immediately; after release grant order restarts at requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources,
// plus a per-register pending-write scoreboard used by issue for RAW/WAW stalls.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int REG_W  = 5,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*REG_W-1:0]    req_rd,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    input  logic                     iss_valid,
    input  logic [REG_W-1:0]         iss_rd,
    output logic                     rf_wen,
    output logic [REG_W-1:0]         rf_wsel,
    output logic [WORD_W-1:0]        rf_wdat,
    output logic [(2**REG_W)-1:0]    busy
);

    localparam int NREGS = 2**REG_W;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_wen;
    logic [REG_W-1:0]  r_wsel;
    logic [WORD_W-1:0] r_wdat;
    logic [NREGS-1:0]  r_busy;

    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_gnt_any;
    logic [NREQ-1:0]   w_gnt;
    logic              w_xfer;
    logic [PTR_W-1:0]  w_ptr_next;
    logic [REG_W-1:0]  w_rd_arr   [NREQ];
    logic [WORD_W-1:0] w_data_arr [NREQ];
    logic [REG_W-1:0]  w_sel_rd;
    logic [WORD_W-1:0] w_sel_data;
    logic [NREGS-1:0]  w_busy_next;

    // Search valids starting at the pointer, wrapping once around the requesters.
    always_comb begin : arb_search
        int v_idx;
        v_idx     = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_gnt_any && req_valid[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PTR_W'(v_idx);
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_gnt[gi]      = w_gnt_any && (w_gnt_idx == PTR_W'(gi));
        assign w_rd_arr[gi]   = req_rd[gi*REG_W +: REG_W];
        assign w_data_arr[gi] = req_data[gi*WORD_W +: WORD_W];
    end

    // No grant may be advertised while the output stage is held in reset.
    assign req_ready  = nrst ? w_gnt : '0;
    assign w_xfer     = w_gnt_any && nrst;
    assign w_sel_rd   = w_rd_arr[w_gnt_idx];
    assign w_sel_data = w_data_arr[w_gnt_idx];
    assign w_ptr_next = (w_gnt_idx == PTR_W'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr  <= '0;
            r_wen  <= 1'b0;
            r_wsel <= '0;
            r_wdat <= '0;
        end else begin
            r_wen <= 1'b0;
            if (w_xfer) begin
                r_ptr  <= w_ptr_next;
                r_wen  <= (w_sel_rd != '0);
                r_wsel <= w_sel_rd;
                r_wdat <= w_sel_data;
            end
        end
    end

    // Set has priority over clear so a re-issue on the writeback edge stays pending.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
        if (gi == 0) begin : g_x0
            assign w_busy_next[gi] = 1'b0;
        end else begin : g_xr
            assign w_busy_next[gi] = (iss_valid && (iss_rd == REG_W'(gi)))
                                   || (r_busy[gi] && !(r_wen && (r_wsel == REG_W'(gi))));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign rf_wen  = r_wen;
    assign rf_wsel = r_wsel;
    assign rf_wdat = r_wdat;
    assign busy    = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, compared each cycle against a behavioural model of grants, writes and busy bits.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int REG_W  = 5;
    localparam int WORD_W = 32;
    localparam int NREGS  = 2**REG_W;

    logic                    clk;
    logic                    nrst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*REG_W-1:0]   req_rd;
    logic [NREQ*WORD_W-1:0]  req_data;
    logic                    iss_valid;
    logic [REG_W-1:0]        iss_rd;
    logic                    rf_wen;
    logic [REG_W-1:0]        rf_wsel;
    logic [WORD_W-1:0]       rf_wdat;
    logic [NREGS-1:0]        busy;

    regfile_wb_arbiter #(.NREQ(NREQ), .REG_W(REG_W), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_wen    (rf_wen),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int last_grant;

    // Model state: next requester to favour, expected write port, pending registers.
    int                m_ptr;
    logic              m_wen;
    logic [REG_W-1:0]  m_wsel;
    logic [WORD_W-1:0] m_wdat;
    logic [NREGS-1:0]  m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int i, input logic [REG_W-1:0] rd, input logic [WORD_W-1:0] data);
        if (!req_valid[i]) begin
            req_valid[i]                 = 1'b1;
            req_rd[i*REG_W +: REG_W]     = rd;
            req_data[i*WORD_W +: WORD_W] = data;
        end
    endtask

    task automatic issue(input logic [REG_W-1:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        #2;
        chk("rst_wen",   rf_wen,    0);
        chk("rst_wsel",  rf_wsel,   0);
        chk("rst_wdat",  rf_wdat,   0);
        chk("rst_busy",  busy,      0);
        chk("rst_ready", req_ready, 0);
        m_ptr  = 0;
        m_wen  = 1'b0;
        m_wsel = '0;
        m_wdat = '0;
        m_busy = '0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // One clock: check the grant, step the model across the edge, check the registered side.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_rdy;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        last_grant = g;
        @(posedge clk);
        if (m_wen) m_busy[m_wsel] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        if (g >= 0) begin
            m_wsel = req_rd[g*REG_W +: REG_W];
            m_wdat = req_data[g*WORD_W +: WORD_W];
            m_wen  = (m_wsel != 0);
            m_ptr  = (g + 1) % NREQ;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk("rf_wen",  rf_wen,  m_wen);
        chk("rf_wsel", rf_wsel, m_wsel);
        chk("rf_wdat", rf_wdat, m_wdat);
        chk("busy",    busy,    m_busy);
        if (g >= 0) req_valid[g] = 1'b0;
        iss_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int wait0;
        nrst      = 1'b0;
        req_valid = 3'b101;
        req_rd    = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        apply_reset();
        req_valid = '0;

        // Single request: granted same cycle, written the next, quiet after.
        offer(0, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("t1_grant", last_grant, 0);
        chk("t1_wen",   rf_wen,  1);
        chk("t1_wsel",  rf_wsel, 5);
        chk("t1_wdat",  rf_wdat, 32'hDEADBEEF);
        cycle();
        chk("t1_wen_off", rf_wen, 0);

        // All valid after reset: strict rotation 0,1,2,0,1,2.
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) offer(i, 5'(8*i + c + 1), $urandom());
            cycle();
            chk("t2_order", last_grant, c % NREQ);
        end
        for (int c = 0; c < 3; c++) cycle();

        // Fairness: req1 always valid, req0 every other cycle.
        wait0 = 0;
        for (int c = 0; c < 14; c++) begin
            offer(1, 5'($urandom_range(1, 31)), $urandom());
            if (c % 2 == 0) offer(0, 5'($urandom_range(1, 31)), $urandom());
            if (req_valid[0]) begin
                cycle();
                if (last_grant == 0) wait0 = 0;
                else wait0++;
                chk("t3_wait_le1", (wait0 <= 1), 1);
            end else begin
                cycle();
            end
        end
        for (int c = 0; c < 3; c++) cycle();

        // Scoreboard set, clear, and set-wins on the writeback edge.
        issue(5'd7);
        cycle();
        chk("t4_set", busy[7], 1);
        offer(1, 5'd7, 32'h0000_0077);
        cycle();
        cycle();
        chk("t4_clear", busy[7], 0);
        issue(5'd7);
        cycle();
        offer(2, 5'd7, 32'h0000_0078);
        cycle();
        chk("t4_wen7", rf_wen, 1);
        issue(5'd7);
        cycle();
        chk("t4_setwins", busy[7], 1);

        // x0: no busy bit, no write, but the slot and pointer are consumed.
        apply_reset();
        issue(5'd0);
        offer(0, 5'd0, 32'h1);
        cycle();
        chk("t5_busy0", busy, 0);
        chk("t5_grant", last_grant, 0);
        chk("t5_wen",   rf_wen, 0);
        for (int i = 0; i < NREQ; i++) offer(i, 5'(i + 20), $urandom());
        cycle();
        chk("t5_next_grant", last_grant, 1);
        for (int c = 0; c < 3; c++) cycle();

        // Reset mid-operation with busy bits and a write in flight.
        apply_reset();
        issue(5'd3);
        cycle();
        issue(5'd9);
        offer(1, 5'd12, 32'hCAFE_F00D);
        cycle();
        chk("t6_inflight", rf_wen, 1);
        chk("t6_busy39", {busy[9], busy[3]}, 2'b11);
        offer(0, 5'd4, 32'h4444);
        offer(2, 5'd6, 32'h6666);
        apply_reset();
        cycle();
        chk("t6_first_grant", last_grant, 0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) != 0) offer(i, 5'($urandom_range(0, 31)), $urandom());
            end
            if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 31)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
